// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the conditional-branch predictor slice:
//   - RV32I opcode[6:2] encodings used by the fetch/kill logic
//   - 2-bit saturating counter state names
//   - B-immediate extraction and saturating counter step helpers
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam logic [4:0] B_TYPE    = 5'b11000;
    localparam logic [4:0] JAL_TYPE  = 5'b11011;
    localparam logic [4:0] JALR_TYPE = 5'b11001;

    // Counter states: strongly/weakly not-taken, weakly/strongly taken.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    // True when the instruction is a conditional branch.
    function automatic logic is_btype(input logic [31:0] inst);
        return (inst[6:2] == B_TYPE);
    endfunction

    // Sign-extended B-type immediate (bit 0 is always zero).
    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // One training step of a 2-bit counter; clamps at both ends.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] r;
        if (taken) begin
            if (cnt == ST) r = ST;
            else           r = cnt + 2'd1;
        end else begin
            if (cnt == SNT) r = SNT;
            else            r = cnt - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Pipeline <-> predictor signal bundle.
//   master : pipeline side (drives F/X stage info, consumes prediction results)
//   slave  : predictor side
// Signals: stall, pcF, instF, predict_taken, predict_target, pcX, instX,
//          in_killX, branch_taken, branch_target, predict_fail, redirect_pc,
//          branch_count, mispredict_count.
// -----------------------------------------------------------------------------
interface branch_predictor_if;
    logic        stall;
    logic [31:0] pcF;
    logic [31:0] instF;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic [31:0] pcX;
    logic [31:0] instX;
    logic        in_killX;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        predict_fail;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output stall, pcF, instF, pcX, instX, in_killX, branch_taken, branch_target,
        input  predict_taken, predict_target, predict_fail, redirect_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  stall, pcF, instF, pcX, instX, in_killX, branch_taken, branch_target,
        output predict_taken, predict_target, predict_fail, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bht_sat_counter_table.sv
// -----------------------------------------------------------------------------
// bht_sat_counter_table
// 2^IDX_W entries of 2-bit saturating counters.
//   clk, rst      : clock, synchronous active-high reset (all entries -> CNT_INIT)
//   rd_idx_i      : combinational read index
//   rd_cnt_o      : counter at rd_idx_i (pre-update value in an update cycle)
//   upd_en_i      : train the entry at upd_idx_i on this edge
//   upd_idx_i     : entry to train
//   upd_taken_i   : step direction (1 = towards taken)
// -----------------------------------------------------------------------------
module bht_sat_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int          IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] upd_cnt_d;

    // No bypass: a read hitting the entry being trained sees the old value.
    assign rd_cnt_o  = cnt_q[rd_idx_i];
    assign upd_cnt_d = sat_next(cnt_q[upd_idx_i], upd_taken_i);

    // Counter array: reset to the init value, otherwise train one entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= upd_cnt_d;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Predicts conditional-branch direction in F, carries the prediction through
// D and X, flags mispredicts in X and supplies the restart PC.
//   clk, rst : clock, synchronous active-high reset
//   bp       : branch_predictor_if.slave bundle (see interface header)
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bp
);
    logic [1:0]  rd_cnt_s;
    logic        predict_taken_s;
    logic        valid_br_s;
    logic        predict_fail_s;

    logic        pred_d_q, pred_d_d;
    logic        pred_x_q, pred_x_d;
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Instruction bits not involved in opcode or immediate decode.
    logic        unused_s;
    assign unused_s = ^{bp.instF[24:12], bp.instF[1:0], bp.instX[31:7], bp.instX[1:0]};

    bht_sat_counter_table #(
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (bp.pcF[IDX_W+1:2]),
        .rd_cnt_o    (rd_cnt_s),
        .upd_en_i    (valid_br_s),
        .upd_idx_i   (bp.pcX[IDX_W+1:2]),
        .upd_taken_i (bp.branch_taken)
    );

    assign predict_taken_s = is_btype(bp.instF) && rd_cnt_s[1];
    assign valid_br_s      = !bp.in_killX && is_btype(bp.instX);
    assign predict_fail_s  = valid_br_s && (pred_x_q != bp.branch_taken);

    assign bp.predict_taken    = predict_taken_s;
    assign bp.predict_target   = bp.pcF + b_imm(bp.instF);
    assign bp.predict_fail     = predict_fail_s;
    assign bp.redirect_pc      = bp.branch_taken ? bp.branch_target : (bp.pcX + 32'd4);
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

    // Next state for the prediction pipe and the perf counters.
    always_comb begin
        pred_d_d           = pred_d_q;
        pred_x_d           = 1'b0;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        // A stall freezes D and pushes a bubble (not-taken) into X.
        if (!bp.stall) begin
            pred_d_d = predict_taken_s;
            pred_x_d = pred_d_q;
        end else begin
            pred_d_d = pred_d_q;
            pred_x_d = 1'b0;
        end

        if (valid_br_s) begin
            branch_count_d = branch_count_q + 32'd1;
        end else begin
            branch_count_d = branch_count_q;
        end

        if (predict_fail_s) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end else begin
            mispredict_count_d = mispredict_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_d_q           <= 1'b0;
            pred_x_q           <= 1'b0;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            pred_d_q           <= pred_d_d;
            pred_x_q           <= pred_x_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed scenarios plus a randomized run against a behavioural model of the
// predictor (table of saturating integers, two-slot prediction pipe, counters).
// -----------------------------------------------------------------------------
module tb_branch_predictor;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    branch_predictor_if bp ();

    branch_predictor #(.IDX_W(6), .CNT_INIT(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    int          m_bht [64];
    bit          m_pd, m_px;
    int unsigned m_bc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit isb(input logic [31:0] inst);
        return inst[6:0] == 7'b1100011 || inst[6:2] == 5'b11000;
    endfunction

    // B-immediate by weighted sum of fields.
    function automatic logic [31:0] imm_of(input logic [31:0] inst);
        int v;
        v = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
            + int'(inst[11:8]) * 2;
        return 32'(v);
    endfunction

    function automatic logic [31:0] mk_b(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic bit exp_pt();
        return isb(bp.instF) && (m_bht[idx_of(bp.pcF)] >= 2);
    endfunction

    function automatic bit exp_fail();
        return !bp.in_killX && isb(bp.instX) && (m_px != bp.branch_taken);
    endfunction

    function automatic logic [31:0] exp_redirect();
        return bp.branch_taken ? bp.branch_target : bp.pcX + 32'd4;
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit pt, valid, fail, taken, stl, r;
        int xi;
        pt    = exp_pt();
        valid = !bp.in_killX && isb(bp.instX);
        fail  = exp_fail();
        taken = bp.branch_taken;
        stl   = bp.stall;
        r     = rst;
        xi    = idx_of(bp.pcX);
        @(posedge clk);
        #1;
        if (r) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_pd = 0; m_px = 0; m_bc = 0; m_mc = 0;
        end else begin
            if (valid) begin
                if (taken) m_bht[xi] = (m_bht[xi] == 3) ? 3 : m_bht[xi] + 1;
                else       m_bht[xi] = (m_bht[xi] == 0) ? 0 : m_bht[xi] - 1;
                m_bc++;
                if (fail) m_mc++;
            end
            if (stl) begin
                m_px = 0;
            end else begin
                m_px = m_pd;
                m_pd = pt;
            end
        end
    endtask

    task automatic set_idle();
        bp.stall = 0; bp.pcF = 32'h0; bp.instF = NOP;
        bp.pcX = 32'h0; bp.instX = NOP; bp.in_killX = 0;
        bp.branch_taken = 0; bp.branch_target = 32'h0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; tick(); tick();
        bp.instX = mk_b(32'd8); bp.pcX = 32'h40; bp.branch_taken = 1;
        #1;
        n_cmp++; if (bp.branch_count !== 32'd0) begin n_err++; $display("FAIL reset_bc: got %0d want 0", bp.branch_count); end
        n_cmp++; if (bp.mispredict_count !== 32'd0) begin n_err++; $display("FAIL reset_mc: got %0d want 0", bp.mispredict_count); end
        n_cmp++; if (bp.predict_fail !== 1'b1) begin n_err++; $display("FAIL reset_predx_zero: got %0b want 1", bp.predict_fail); end
        rst = 0; set_idle();
    endtask

    task automatic test_fetch_predict();
        do_reset();
        bp.pcF = 32'h100; bp.instF = mk_b(32'd16);
        #1;
        n_cmp++; if (bp.predict_taken !== 1'b0) begin n_err++; $display("FAIL fetch_pt: got %0b want 0", bp.predict_taken); end
        n_cmp++; if (bp.predict_target !== 32'h110) begin n_err++; $display("FAIL fetch_target: got %h want 00000110", bp.predict_target); end
        bp.pcF = 32'h0000_0004; bp.instF = mk_b(32'hFFFF_FFF0);
        #1;
        n_cmp++; if (bp.predict_target !== 32'hFFFF_FFF4) begin n_err++; $display("FAIL fetch_target_wrap: got %h want fffffff4", bp.predict_target); end
        set_idle();
    endtask

    task automatic test_loop_branch();
        bit exp_p [3] = '{1'b0, 1'b1, 1'b1};
        bit exp_f [3] = '{1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bp.pcF = 32'h200; bp.instF = mk_b(32'hFFFF_FFF8);
            #1;
            n_cmp++; if (bp.predict_taken !== exp_p[i]) begin n_err++; $display("FAIL loop_pt[%0d]: got %0b want %0b", i, bp.predict_taken, exp_p[i]); end
            tick();
            bp.instF = NOP; tick();
            bp.pcX = 32'h200; bp.instX = mk_b(32'hFFFF_FFF8); bp.branch_taken = 1; bp.branch_target = 32'h1F8;
            #1;
            n_cmp++; if (bp.predict_fail !== exp_f[i]) begin n_err++; $display("FAIL loop_fail[%0d]: got %0b want %0b", i, bp.predict_fail, exp_f[i]); end
            n_cmp++; if (bp.redirect_pc !== 32'h1F8) begin n_err++; $display("FAIL loop_redirect[%0d]: got %h want 000001f8", i, bp.redirect_pc); end
            tick();
            bp.instX = NOP; bp.branch_taken = 0;
        end
        n_cmp++; if (bp.branch_count !== 32'd3) begin n_err++; $display("FAIL loop_bc: got %0d want 3", bp.branch_count); end
        n_cmp++; if (bp.mispredict_count !== 32'd1) begin n_err++; $display("FAIL loop_mc: got %0d want 1", bp.mispredict_count); end
    endtask

    task automatic test_mispredict_redirect();
        do_reset();
        bp.pcX = 32'h300; bp.instX = mk_b(32'h40); bp.branch_taken = 1; bp.branch_target = 32'h340;
        tick(); tick();
        bp.instX = NOP;
        bp.pcF = 32'h300; bp.instF = mk_b(32'h40);
        #1;
        n_cmp++; if (bp.predict_taken !== 1'b1) begin n_err++; $display("FAIL misp_pt_strong: got %0b want 1", bp.predict_taken); end
        tick();
        bp.instF = NOP; tick();
        bp.instX = mk_b(32'h40); bp.branch_taken = 0;
        #1;
        n_cmp++; if (bp.predict_fail !== 1'b1) begin n_err++; $display("FAIL misp_fail: got %0b want 1", bp.predict_fail); end
        n_cmp++; if (bp.redirect_pc !== 32'h304) begin n_err++; $display("FAIL misp_redirect: got %h want 00000304", bp.redirect_pc); end
        tick();
        bp.instX = NOP; bp.instF = mk_b(32'h40);
        #1;
        n_cmp++; if (bp.predict_taken !== 1'b1) begin n_err++; $display("FAIL misp_pt_weak: got %0b want 1", bp.predict_taken); end
        bp.instF = NOP; bp.instX = mk_b(32'h40); bp.branch_taken = 0;
        tick();
        bp.instX = NOP; bp.instF = mk_b(32'h40);
        #1;
        n_cmp++; if (bp.predict_taken !== 1'b0) begin n_err++; $display("FAIL misp_pt_after2: got %0b want 0", bp.predict_taken); end
        n_cmp++; if (bp.mispredict_count !== 32'd3) begin n_err++; $display("FAIL misp_mc: got %0d want 3", bp.mispredict_count); end
        set_idle();
    endtask

    task automatic test_kill();
        do_reset();
        bp.pcX = 32'h400; bp.instX = mk_b(32'h8); bp.in_killX = 1; bp.branch_taken = 1;
        #1;
        n_cmp++; if (bp.predict_fail !== 1'b0) begin n_err++; $display("FAIL kill_fail: got %0b want 0", bp.predict_fail); end
        tick();
        bp.in_killX = 0; bp.instX = NOP; bp.branch_taken = 0;
        bp.pcF = 32'h400; bp.instF = mk_b(32'h8);
        #1;
        n_cmp++; if (bp.branch_count !== 32'd0) begin n_err++; $display("FAIL kill_bc: got %0d want 0", bp.branch_count); end
        n_cmp++; if (bp.predict_taken !== 1'b0) begin n_err++; $display("FAIL kill_no_train: got %0b want 0", bp.predict_taken); end
        set_idle();
    endtask

    task automatic test_stall();
        do_reset();
        bp.pcX = 32'h500; bp.instX = mk_b(32'h20); bp.branch_taken = 1;
        tick();
        bp.instX = NOP; bp.branch_taken = 0;
        bp.pcF = 32'h500; bp.instF = mk_b(32'h20);
        #1;
        n_cmp++; if (bp.predict_taken !== 1'b1) begin n_err++; $display("FAIL stall_pt: got %0b want 1", bp.predict_taken); end
        tick();
        bp.instF = NOP; bp.stall = 1; tick();
        bp.pcX = 32'h700; bp.instX = mk_b(32'h20); bp.branch_taken = 0;
        #1;
        n_cmp++; if (bp.predict_fail !== 1'b0) begin n_err++; $display("FAIL stall_bubble1: got %0b want 0", bp.predict_fail); end
        tick();
        bp.stall = 0;
        #1;
        n_cmp++; if (bp.predict_fail !== 1'b0) begin n_err++; $display("FAIL stall_bubble2: got %0b want 0", bp.predict_fail); end
        tick();
        bp.pcX = 32'h500;
        #1;
        n_cmp++; if (bp.predict_fail !== 1'b1) begin n_err++; $display("FAIL stall_release: got %0b want 1", bp.predict_fail); end
        n_cmp++; if (bp.redirect_pc !== 32'h504) begin n_err++; $display("FAIL stall_redirect: got %h want 00000504", bp.redirect_pc); end
        tick();
        set_idle();
    endtask

    task automatic test_same_index_and_reset();
        do_reset();
        bp.pcF = 32'h800; bp.instF = mk_b(32'h10);
        bp.pcX = 32'h800; bp.instX = mk_b(32'h10); bp.branch_taken = 1; bp.branch_target = 32'h810;
        #1;
        n_cmp++; if (bp.predict_taken !== 1'b0) begin n_err++; $display("FAIL same_idx_old: got %0b want 0", bp.predict_taken); end
        tick();
        bp.instX = NOP; bp.branch_taken = 0;
        #1;
        n_cmp++; if (bp.predict_taken !== 1'b1) begin n_err++; $display("FAIL same_idx_new: got %0b want 1", bp.predict_taken); end
        tick(); tick();
        rst = 1; tick();
        bp.instX = mk_b(32'h10); bp.branch_taken = 0;
        #1;
        n_cmp++; if (bp.branch_count !== 32'd0) begin n_err++; $display("FAIL midrst_bc: got %0d want 0", bp.branch_count); end
        n_cmp++; if (bp.mispredict_count !== 32'd0) begin n_err++; $display("FAIL midrst_mc: got %0d want 0", bp.mispredict_count); end
        n_cmp++; if (bp.predict_taken !== 1'b0) begin n_err++; $display("FAIL midrst_table: got %0b want 0", bp.predict_taken); end
        n_cmp++; if (bp.predict_fail !== 1'b0) begin n_err++; $display("FAIL midrst_predx: got %0b want 0", bp.predict_fail); end
        rst = 0; set_idle();
    endtask

    function automatic logic [31:0] rpc();
        return 32'h1000 + 32'(4 * $urandom_range(0, 7)) + ($urandom_range(0, 1) ? 32'd256 : 32'd0);
    endfunction

    function automatic logic [31:0] rinst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r[6:0] = 7'b1100011;
        else if (r[6:2] == 5'b11000) r[2] = ~r[2];
        return r;
    endfunction

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rst              = ($urandom_range(0, 63) == 0);
            bp.stall         = ($urandom_range(0, 3) == 0);
            bp.pcF           = rpc();
            bp.instF         = rinst();
            bp.pcX           = rpc();
            bp.instX         = rinst();
            bp.in_killX      = ($urandom_range(0, 3) == 0);
            bp.branch_taken  = 1'($urandom_range(0, 1));
            bp.branch_target = $urandom;
            #1;
            n_cmp++; if (bp.predict_taken !== exp_pt()) begin n_err++; $display("FAIL rnd_pt[%0d]: got %0b want %0b", c, bp.predict_taken, exp_pt()); end
            if (isb(bp.instF)) begin
                n_cmp++; if (bp.predict_target !== bp.pcF + imm_of(bp.instF)) begin n_err++; $display("FAIL rnd_target[%0d]: got %h want %h", c, bp.predict_target, bp.pcF + imm_of(bp.instF)); end
            end
            n_cmp++; if (bp.predict_fail !== exp_fail()) begin n_err++; $display("FAIL rnd_fail[%0d]: got %0b want %0b", c, bp.predict_fail, exp_fail()); end
            n_cmp++; if (bp.redirect_pc !== exp_redirect()) begin n_err++; $display("FAIL rnd_redirect[%0d]: got %h want %h", c, bp.redirect_pc, exp_redirect()); end
            n_cmp++; if (bp.branch_count !== m_bc) begin n_err++; $display("FAIL rnd_bc[%0d]: got %0d want %0d", c, bp.branch_count, m_bc); end
            n_cmp++; if (bp.mispredict_count !== m_mc) begin n_err++; $display("FAIL rnd_mc[%0d]: got %0d want %0d", c, bp.mispredict_count, m_mc); end
            tick();
        end
        rst = 0; set_idle();
    endtask

    initial begin
        rst = 1;
        set_idle();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_pd = 0; m_px = 0; m_bc = 0; m_mc = 0;
        test_reset();
        test_fetch_predict();
        test_loop_branch();
        test_mispredict_redirect();
        test_kill();
        test_stall();
        test_same_index_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
